// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity mode codes and the
// bit-period helper used by both the transmitter and the receiver.
package uart_pkg;

    // Frame phases, 3-bit encoding
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // Parity mode codes for the PARITY parameter
    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    // Number of system clocks per line bit
    function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter. Counts 0..CLKS_PER_BIT-1 and pulses bit_end during the
// last clock of every bit period; wraps to 0 after it. clr holds it at 0 so
// that a bit period starts exactly on the edge where clr is released.
// Ports:
//   clk      in  system clock
//   rst      in  synchronous active-high reset
//   clr      in  hold counter at zero
//   bit_end  out high during the final clock of a bit period
module uart_baud_cnt
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic bit_end
);

    localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);

    logic [15:0] clk_count;

    assign bit_end = (clk_count == LAST_CNT);

    always_ff @(posedge clk) begin
        if (rst || clr || bit_end) begin
            clk_count <= '0;
        end else begin
            clk_count <= clk_count + 16'd1;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter. Accepts a word over a valid/ready handshake and sends
// start bit, data LSB first, optional parity bit and 1 or 2 stop bits.
// Ports:
//   clk       in  system clock
//   rst       in  synchronous active-high reset (aborts a frame in progress)
//   tx_data   in  word to send, sampled on the handshake edge only
//   tx_valid  in  upstream has a word
//   tx_ready  out block can accept a word (registered)
//   tx        out serial line, idle high (registered)
//   tx_busy   out frame in progress
//   tx_done   out one-cycle pulse after the last stop bit
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int FRAME_BITS = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [FRAME_BITS-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  tx,
    output logic                  tx_busy,
    output logic                  tx_done
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam logic [3:0] LAST_DATA = 4'(FRAME_BITS - 1);
    localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

    if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65536) begin : g_bad_cpb
        $error("uart_tx: CLKS_PER_BIT must be 2..65536");
    end
    if (FRAME_BITS < 5 || FRAME_BITS > 9) begin : g_bad_frame
        $error("uart_tx: FRAME_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_tx: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("uart_tx: STOP_BITS must be 1 or 2");
    end

    state_t                state_q, state_d;
    logic                  tx_q, tx_d;
    logic                  ready_q, ready_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [3:0]            bit_idx_q, bit_idx_d;
    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic                  par_q, par_d;
    logic                  bit_end;
    logic                  handshake;

    assign handshake = tx_valid && ready_q;

    // Counter idles at zero so the start bit lasts exactly one bit period
    uart_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr     (state_q == ST_IDLE),
        .bit_end (bit_end)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            tx_q      <= 1'b1;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            bit_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            tx_q      <= tx_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            bit_idx_q <= bit_idx_d;
        end
    end

    // Datapath registers carry no reset; they are reloaded on every handshake
    always_ff @(posedge clk) begin
        shift_q <= shift_d;
        par_q   <= par_d;
    end

    always_comb begin
        state_d   = state_q;
        tx_d      = tx_q;
        ready_d   = ready_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        par_d     = par_q;

        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (handshake) begin
                    shift_d   = tx_data;
                    // Parity fixed from the captured word; the shift register
                    // is consumed as the data bits go out
                    par_d     = (PARITY == PAR_ODD) ? ~^tx_data : ^tx_data;
                    tx_d      = 1'b0;
                    ready_d   = 1'b0;
                    busy_d    = 1'b1;
                    bit_idx_d = '0;
                    state_d   = ST_START;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    tx_d      = shift_q[0];
                    bit_idx_d = '0;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    if (bit_idx_q == LAST_DATA) begin
                        bit_idx_d = '0;
                        if (PARITY != PAR_NONE) begin
                            tx_d    = par_q;
                            state_d = ST_PARITY;
                        end else begin
                            tx_d    = 1'b1;
                            state_d = ST_STOP;
                        end
                    end else begin
                        // LSB-first: next bit is always at position 1 before the shift
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                        bit_idx_d = bit_idx_q + 4'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    tx_d      = 1'b1;
                    bit_idx_d = '0;
                    state_d   = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (bit_idx_q == LAST_STOP) begin
                        tx_d      = 1'b1;
                        ready_d   = 1'b1;
                        busy_d    = 1'b0;
                        done_d    = 1'b1;
                        bit_idx_d = '0;
                        state_d   = ST_IDLE;
                    end else begin
                        bit_idx_d = bit_idx_q + 4'd1;
                    end
                end
            end
            default: begin
                tx_d      = 1'b1;
                ready_d   = 1'b1;
                busy_d    = 1'b0;
                bit_idx_d = '0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    assign tx       = tx_q;
    assign tx_ready = ready_q;
    assign tx_busy  = busy_q;
    assign tx_done  = done_q;

endmodule
